// File: rtl/ahb_mtx_out_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mtx_pkg
// Brief    : AHB transfer/burst encodings and burst beat-count constants
//            shared by the matrix output-stage arbiter.
// Revision : 1.0
// ============================================================================
package ahb_mtx_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    // Remaining SEQ beats after the NONSEQ of a fixed-length burst
    localparam logic [3:0] BURST16_CNT  = 4'd15;
    localparam logic [3:0] BURST8_CNT   = 4'd7;
    localparam logic [3:0] BURST4_CNT   = 4'd3;
    localparam logic [7:0] INCR_CNT_MAX = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/ahb_mtx_out_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mtx_out_arb_if
// Brief    : Request/bus-status bundle between the slave-side bus and the
//            output-stage arbiter, with grant results returned.
// Revision : 1.0
// ============================================================================
interface ahb_mtx_out_arb_if #(
    parameter int NUM_PORTS = 3,
    parameter int PW        = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PW-1:0]        addr_in_port;
    logic                 no_port;

    modport master (
        output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        input  addr_in_port, no_port
    );

    modport slave (
        input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
        output addr_in_port, no_port
    );
endinterface
`default_nettype wire

// File: rtl/ahb_mtx_burst_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mtx_burst_tracker
// Brief    : Follows the current burst on the slave side and reports whether
//            the owning port must be retained or its INCR allowance is spent.
// Revision : 1.0
// ============================================================================
module ahb_mtx_burst_tracker
    import ahb_mtx_pkg::*;
#(
    parameter int INCR_LIMIT = 0
) (
    input  logic       hclk_i,
    input  logic       hresetn_i,
    input  logic       hready_i,
    input  logic       hsel_i,
    input  logic [1:0] htrans_i,
    input  logic [2:0] hburst_i,
    output logic       next_hold_o,
    output logic       incr_expired_o
);

    localparam logic [7:0] LIMIT = 8'(INCR_LIMIT);

    htrans_e    trans;
    hburst_e    burst;
    logic [3:0] count_q, count_d;
    logic       hold_q, hold_d;
    logic [7:0] incr_cnt_q, incr_cnt_d;

    assign trans = htrans_e'(htrans_i);
    assign burst = hburst_e'(hburst_i);

    always_comb begin
        count_d    = count_q;
        hold_d     = hold_q;
        incr_cnt_d = incr_cnt_q;
        if (!hready_i) begin
            count_d    = count_q;
        end else if (!hsel_i) begin
            count_d    = '0;
            hold_d     = 1'b0;
            incr_cnt_d = '0;
        end else begin
            case (trans)
                HTRANS_NONSEQ: begin
                    case (burst)
                        HBURST_WRAP16, HBURST_INCR16: begin count_d = BURST16_CNT; hold_d = 1'b1; end
                        HBURST_WRAP8,  HBURST_INCR8:  begin count_d = BURST8_CNT;  hold_d = 1'b1; end
                        HBURST_WRAP4,  HBURST_INCR4:  begin count_d = BURST4_CNT;  hold_d = 1'b1; end
                        default:                      begin count_d = '0;          hold_d = 1'b0; end
                    endcase
                    incr_cnt_d = (burst == HBURST_INCR) ? 8'd1 : 8'd0;
                end
                HTRANS_SEQ: begin
                    if (count_q != 4'd0) count_d = count_q - 4'd1;
                    if (count_q == 4'd1) hold_d  = 1'b0;
                    if ((incr_cnt_q != 8'd0) && (incr_cnt_q != INCR_CNT_MAX))
                        incr_cnt_d = incr_cnt_q + 8'd1;
                end
                HTRANS_BUSY: begin
                    count_d = count_q;
                end
                HTRANS_IDLE: begin
                    count_d    = '0;
                    hold_d     = 1'b0;
                    incr_cnt_d = '0;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            count_q    <= '0;
            hold_q     <= 1'b0;
            incr_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            hold_q     <= hold_d;
            incr_cnt_q <= incr_cnt_d;
        end
    end

    assign next_hold_o    = hold_d;
    assign incr_expired_o = (LIMIT != 8'd0) && (incr_cnt_d >= LIMIT);

endmodule
`default_nettype wire

// File: rtl/ahb_mtx_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mtx_out_arb
// Brief    : Per-slave output-stage arbiter of an AHB matrix: picks which
//            input port drives this slave, fixed-priority or round-robin.
// Revision : 1.0
// ============================================================================
module ahb_mtx_out_arb
    import ahb_mtx_pkg::*;
#(
    parameter int                   NUM_PORTS    = 3,
    parameter int                   PW           = $clog2(NUM_PORTS),
    parameter int                   ARB_MODE     = 0,
    parameter logic [NUM_PORTS-1:0] CONNECT_MASK = '1,
    parameter int                   INCR_LIMIT   = 0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_mtx_out_arb_if.slave bus
);

    logic [PW-1:0]        addr_q, addr_d, pick;
    logic                 no_port_q, no_port_d;
    logic                 next_hold, incr_expired, cur_active;
    logic [NUM_PORTS-1:0] eff_req, cur_onehot, cand;

    ahb_mtx_burst_tracker #(
        .INCR_LIMIT (INCR_LIMIT)
    ) u_tracker (
        .hclk_i         (HCLK),
        .hresetn_i      (HRESETn),
        .hready_i       (bus.HREADYM),
        .hsel_i         (bus.HSELM),
        .htrans_i       (bus.HTRANSM),
        .hburst_i       (bus.HBURSTM),
        .next_hold_o    (next_hold),
        .incr_expired_o (incr_expired)
    );

    assign eff_req    = bus.req_port & CONNECT_MASK;
    assign cur_active = bus.HSELM && (bus.HTRANSM != HTRANS_IDLE) && !incr_expired;

    // The port currently on the bus competes alongside new requesters
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_onehot
        assign cur_onehot[i] = cur_active && (addr_q == PW'(i));
    end
    assign cand = eff_req | cur_onehot;

    if (ARB_MODE == 1) begin : g_rr
        logic [PW-1:0] rr_q;

        // Descending offsets so the nearest candidate after rr_q wins last
        always_comb begin : p_pick
            int idx;
            pick = '0;
            for (int i = NUM_PORTS; i >= 1; i--) begin
                idx = int'(rr_q) + i;
                if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                if (cand[idx[PW-1:0]]) pick = idx[PW-1:0];
            end
        end

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                rr_q <= PW'(NUM_PORTS - 1);
            end else if (bus.HREADYM && !no_port_d) begin
                rr_q <= addr_d;
            end
        end
    end else begin : g_fixed
        always_comb begin
            pick = '0;
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (cand[PW'(i)]) pick = PW'(i);
            end
        end
    end

    always_comb begin
        addr_d    = addr_q;
        no_port_d = 1'b0;
        if (bus.HMASTLOCKM || next_hold) begin
            addr_d = addr_q;
        end else if (|cand) begin
            addr_d = pick;
        end else if (!bus.HSELM) begin
            no_port_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q    <= '0;
            no_port_q <= 1'b1;
        end else if (bus.HREADYM) begin
            addr_q    <= addr_d;
            no_port_q <= no_port_d;
        end
    end

    assign bus.addr_in_port = addr_q;
    assign bus.no_port      = no_port_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_mtx_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_mtx_out_arb
// Brief    : Directed bench driving three arbiter configurations (fixed with
//            INCR limit, round-robin, sparse mask) from one shared stimulus.
// Revision : 1.0
// ============================================================================
module tb_ahb_mtx_out_arb;
    import ahb_mtx_pkg::*;

    localparam int NP = 4;

    logic          HCLK    = 1'b0;
    logic          HRESETn = 1'b1;
    logic [NP-1:0] req     = '0;
    logic          hready  = 1'b1;
    logic          hsel    = 1'b0;
    logic          lock    = 1'b0;
    logic [1:0]    htrans  = HTRANS_IDLE;
    logic [2:0]    hburst  = HBURST_SINGLE;
    int            checks   = 0;
    int            failures = 0;
    int            rr_exp [8] = '{0, 1, 2, 3, 0, 1, 3, 1};

    always #5 HCLK = ~HCLK;

    ahb_mtx_out_arb_if #(.NUM_PORTS(NP)) if_fp ();
    ahb_mtx_out_arb_if #(.NUM_PORTS(NP)) if_rr ();
    ahb_mtx_out_arb_if #(.NUM_PORTS(NP)) if_mk ();

    assign {if_fp.req_port, if_fp.HREADYM, if_fp.HSELM, if_fp.HTRANSM, if_fp.HBURSTM, if_fp.HMASTLOCKM} = {req, hready, hsel, htrans, hburst, lock};
    assign {if_rr.req_port, if_rr.HREADYM, if_rr.HSELM, if_rr.HTRANSM, if_rr.HBURSTM, if_rr.HMASTLOCKM} = {req, hready, hsel, htrans, hburst, lock};
    assign {if_mk.req_port, if_mk.HREADYM, if_mk.HSELM, if_mk.HTRANSM, if_mk.HBURSTM, if_mk.HMASTLOCKM} = {req, hready, hsel, htrans, hburst, lock};

    ahb_mtx_out_arb #(.NUM_PORTS(NP), .ARB_MODE(0), .CONNECT_MASK(4'b1111), .INCR_LIMIT(4))
        u_fp (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if_fp));
    ahb_mtx_out_arb #(.NUM_PORTS(NP), .ARB_MODE(1), .CONNECT_MASK(4'b1111), .INCR_LIMIT(0))
        u_rr (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if_rr));
    ahb_mtx_out_arb #(.NUM_PORTS(NP), .ARB_MODE(0), .CONNECT_MASK(4'b0111), .INCR_LIMIT(0))
        u_mk (.HCLK(HCLK), .HRESETn(HRESETn), .bus(if_mk));

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic [NP-1:0] r, input logic rdy, input logic sel,
                         input logic [1:0] tr, input logic [2:0] bu, input logic lk);
        req = r; hready = rdy; hsel = sel; htrans = tr; hburst = bu; lock = lk;
        @(posedge HCLK);
        #1;
    endtask

    // Reset is applied between clock edges so the checks see the asynchronous effect
    task automatic do_reset();
        req = '0; hready = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE; hburst = HBURST_SINGLE; lock = 1'b0;
        HRESETn = 1'b0;
        #2;
        check_eq("rst_fp_addr", int'(if_fp.addr_in_port), 0);
        check_eq("rst_fp_nop",  int'(if_fp.no_port), 1);
        check_eq("rst_rr_addr", int'(if_rr.addr_in_port), 0);
        check_eq("rst_rr_nop",  int'(if_rr.no_port), 1);
        check_eq("rst_mk_addr", int'(if_mk.addr_in_port), 0);
        check_eq("rst_mk_nop",  int'(if_mk.no_port), 1);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        #1;
        do_reset();

        // Basic grant, then release to no_port
        cycle(4'b1010, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        check_eq("grant_1010_addr", int'(if_fp.addr_in_port), 1);
        check_eq("grant_1010_nop",  int'(if_fp.no_port), 0);
        cycle(4'b0000, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        check_eq("release_nop",  int'(if_fp.no_port), 1);
        check_eq("release_addr", int'(if_fp.addr_in_port), 1);
        cycle(4'b1111, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        check_eq("fixed_all_addr", int'(if_fp.addr_in_port), 0);

        // INCR8 from port 2 is not broken by port 0, across BUSY and a wait state
        do_reset();
        cycle(4'b0100, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        check_eq("incr8_grant", int'(if_fp.addr_in_port), 2);
        cycle(4'b0100, 1, 1, HTRANS_NONSEQ, HBURST_INCR8, 0);
        check_eq("incr8_b1", int'(if_fp.addr_in_port), 2);
        cycle(4'b0100, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0);
        check_eq("incr8_b2", int'(if_fp.addr_in_port), 2);
        cycle(4'b0101, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0);
        check_eq("incr8_b3", int'(if_fp.addr_in_port), 2);
        cycle(4'b0101, 1, 1, HTRANS_BUSY, HBURST_INCR8, 0);
        check_eq("incr8_busy", int'(if_fp.addr_in_port), 2);
        cycle(4'b0001, 0, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        check_eq("incr8_wait_addr", int'(if_fp.addr_in_port), 2);
        check_eq("incr8_wait_nop",  int'(if_fp.no_port), 0);
        for (int b = 4; b <= 7; b++) begin
            cycle(4'b0101, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0);
            check_eq($sformatf("incr8_b%0d", b), int'(if_fp.addr_in_port), 2);
        end
        cycle(4'b0101, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0);
        check_eq("incr8_after_b8", int'(if_fp.addr_in_port), 0);

        // Round-robin rotation, then sparse requests with wrap
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cycle((k < 5) ? 4'b1111 : 4'b1010, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0);
            check_eq($sformatf("rr_grant%0d", k), int'(if_rr.addr_in_port), rr_exp[k]);
        end

        // INCR limit of 4 beats: preempted by port 3
        do_reset();
        cycle(4'b0010, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        check_eq("lim_grant", int'(if_fp.addr_in_port), 1);
        cycle(4'b1000, 1, 1, HTRANS_NONSEQ, HBURST_INCR, 0);
        check_eq("lim_b1", int'(if_fp.addr_in_port), 1);
        cycle(4'b1000, 1, 1, HTRANS_SEQ, HBURST_INCR, 0);
        check_eq("lim_b2", int'(if_fp.addr_in_port), 1);
        cycle(4'b1000, 1, 1, HTRANS_SEQ, HBURST_INCR, 0);
        check_eq("lim_b3", int'(if_fp.addr_in_port), 1);
        cycle(4'b1000, 1, 1, HTRANS_SEQ, HBURST_INCR, 0);
        check_eq("lim_b4_preempt", int'(if_fp.addr_in_port), 3);

        // Same INCR with no competitor: port 1 retains
        do_reset();
        cycle(4'b0010, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        cycle(4'b0000, 1, 1, HTRANS_NONSEQ, HBURST_INCR, 0);
        for (int b = 2; b <= 5; b++) begin
            cycle(4'b0000, 1, 1, HTRANS_SEQ, HBURST_INCR, 0);
            check_eq($sformatf("lim_keep_b%0d_addr", b), int'(if_fp.addr_in_port), 1);
            check_eq($sformatf("lim_keep_b%0d_nop", b),  int'(if_fp.no_port), 0);
        end

        // Masked port 3 is never granted; lock keeps port 0 until dropped
        do_reset();
        cycle(4'b1000, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        check_eq("mask_nop",  int'(if_mk.no_port), 1);
        check_eq("mask_addr", int'(if_mk.addr_in_port), 0);
        cycle(4'b0001, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        check_eq("lock_grant0", int'(if_mk.addr_in_port), 0);
        check_eq("lock_grant0_nop", int'(if_mk.no_port), 0);
        cycle(4'b0010, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1);
        check_eq("lock_hold_a", int'(if_mk.addr_in_port), 0);
        cycle(4'b0010, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 1);
        check_eq("lock_hold_b", int'(if_mk.addr_in_port), 0);
        cycle(4'b0010, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 1);
        check_eq("lock_hold_c", int'(if_mk.addr_in_port), 0);
        cycle(4'b0010, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 0);
        check_eq("lock_drop", int'(if_mk.addr_in_port), 1);

        // Reset in the middle of an INCR16 burst
        do_reset();
        cycle(4'b0010, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        cycle(4'b0010, 1, 1, HTRANS_NONSEQ, HBURST_INCR16, 0);
        cycle(4'b0010, 1, 1, HTRANS_SEQ, HBURST_INCR16, 0);
        check_eq("mid16_before_rst", int'(if_fp.addr_in_port), 1);
        do_reset();
        cycle(4'b0100, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        check_eq("post_rst_addr", int'(if_fp.addr_in_port), 2);
        check_eq("post_rst_nop",  int'(if_fp.no_port), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
